// File: rtl/artec_dma_regs.sv
// APB register block for the AXIS-to-AXI DMA: one-wait-state slave with
// byte strobes and PSLVERR, sticky W1C status and a maskable interrupt.
module artec_dma_regs #(
   parameter logic [31:0] APB_ID        = 32'h0A3D_0001,
   parameter logic [31:0] VERSION       = 32'h0002_0000,
   parameter int          CH_NUM        = 6,
   parameter int          FB_NUM        = 8,
   parameter int          ADDR_W        = 9,
   parameter logic [31:0] DEFAULT_SIZE  = 32'h0000_1000,
   parameter logic [31:0] OFFSET_STRIDE = 32'h0000_1000
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 psel,
   input  logic                 penable,
   input  logic                 pwrite,
   input  logic [ADDR_W-1:0]    paddr,
   input  logic [31:0]          pwdata,
   input  logic [3:0]           pstrb,
   output logic [31:0]          prdata,
   output logic                 pready,
   output logic                 pslverr,
   output logic                 start_o,
   output logic                 stop_o,
   output logic                 clear_o,
   output logic [FB_NUM*32-1:0] fb_addr_o,
   output logic [31:0]          status_addr_o,
   output logic [CH_NUM-1:0]    ch_enable_o,
   output logic [CH_NUM*32-1:0] ch_size_o,
   output logic [CH_NUM*32-1:0] ch_offset_o,
   output logic                 irq_o,
   input  logic                 finish_i,
   input  logic                 frame_done_i,
   input  logic [31:0]          frame_status_i,
   input  logic [31:0]          frame_number_i,
   input  logic [CH_NUM-1:0]    fifo_ovf_i
);

   logic [FB_NUM-1:0][31:0] fb_q, fb_d;
   logic [CH_NUM-1:0][31:0] size_q, size_d, off_q, off_d;
   logic [31:0]             status_q, status_d;
   logic [CH_NUM-1:0]       chen_q, chen_d, ovf_q, ovf_d;
   logic [2:0]              pend_q, pend_d, mask_q, mask_d;
   logic en_q, en_d, en_dly_q, en_dly_d, clr_q, clr_d, sts_q, sts_d, fin_q, fin_d;
   logic start_q, start_d, stop_q, stop_d, irq_q, irq_d;
   logic pready_q, pready_d, pslverr_q, pslverr_d;
   logic [31:0] prdata_q, prdata_d;

   logic [31:0] widx, bmask, rdata;
   logic        mapped, ro, wr, first, clear_fire;
   logic        unused_addr_lsb;

   assign widx            = 32'(paddr[ADDR_W-1:2]);
   assign unused_addr_lsb = ^paddr[1:0];
   assign bmask           = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
   assign clear_fire      = clr_q & fin_q;
   // first cycle of an access captures read data; commit happens on the pready cycle
   assign first           = psel & penable & ~pready_q;
   assign wr              = pready_q & psel & penable & pwrite & mapped & ~ro;

   function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [31:0] m);
      return (old & ~m) | (wd & m);
   endfunction

   function automatic logic [31:0] rst_off(input int i);
      return OFFSET_STRIDE * 32'(i);
   endfunction

   // address decode and read mux
   always_comb begin
      rdata  = '0;
      mapped = 1'b0;
      ro     = 1'b0;
      case (widx)
         32'd0:  begin mapped = 1'b1; ro = 1'b1; rdata = APB_ID; end
         32'd1:  begin mapped = 1'b1; ro = 1'b1; rdata = VERSION; end
         32'd2:  begin mapped = 1'b1; ro = 1'b1; rdata = {16'(FB_NUM), 16'(CH_NUM)}; end
         32'd3:  begin mapped = 1'b1; rdata = {28'd0, fin_q, sts_q, clr_q, en_q}; end
         32'd4:  begin mapped = 1'b1; ro = 1'b1; rdata = frame_status_i; end
         32'd5:  begin mapped = 1'b1; ro = 1'b1; rdata = frame_number_i; end
         32'd6:  begin mapped = 1'b1; rdata = {29'd0, pend_q}; end
         32'd7:  begin mapped = 1'b1; rdata = {29'd0, mask_q}; end
         32'd8:  begin mapped = 1'b1; rdata = 32'(ovf_q); end
         32'd9:  begin mapped = 1'b1; rdata = status_q; end
         32'd10: begin mapped = 1'b1; rdata = 32'(chen_q); end
         default: ;
      endcase
      for (int i = 0; i < FB_NUM; i++)
         if (widx == 32'(16 + i)) begin mapped = 1'b1; rdata = fb_q[i]; end
      for (int i = 0; i < CH_NUM; i++) begin
         if (widx == 32'(64 + 2 * i)) begin mapped = 1'b1; rdata = size_q[i]; end
         if (widx == 32'(65 + 2 * i)) begin mapped = 1'b1; rdata = off_q[i]; end
      end
   end

   // next-state: writes, then W1C/stsclr, then event sets, then datapath clear
   always_comb begin
      fb_d     = fb_q;
      size_d   = size_q;
      off_d    = off_q;
      status_d = status_q;
      chen_d   = chen_q;
      ovf_d    = ovf_q;
      pend_d   = pend_q;
      mask_d   = mask_q;
      en_d     = en_q;
      en_dly_d = clear_fire ? 1'b0 : en_q;
      clr_d    = clr_q & ~clear_fire;
      sts_d    = 1'b0;
      fin_d    = finish_i;
      start_d  = en_q & ~en_dly_q & ~clear_fire;
      stop_d   = ~en_q & en_dly_q & ~clear_fire;
      irq_d    = |(pend_q & mask_q);
      pready_d = first;
      pslverr_d = first & (pwrite ? (~mapped | ro) : ~mapped);
      prdata_d  = (first & ~pwrite & mapped) ? rdata : 32'd0;

      if (wr) begin
         case (widx)
            32'd3: if (pstrb[0]) begin
               en_d  = pwdata[0];
               clr_d = pwdata[1];
               sts_d = pwdata[2];
            end
            32'd6:  pend_d   = pend_q & ~(pwdata[2:0] & bmask[2:0]);
            32'd7:  mask_d   = (mask_q & ~bmask[2:0]) | (pwdata[2:0] & bmask[2:0]);
            32'd8:  ovf_d    = ovf_q & ~(pwdata[CH_NUM-1:0] & bmask[CH_NUM-1:0]);
            32'd9:  status_d = merge32(status_q, pwdata, bmask);
            32'd10: chen_d   = (chen_q & ~bmask[CH_NUM-1:0]) | (pwdata[CH_NUM-1:0] & bmask[CH_NUM-1:0]);
            default: ;
         endcase
         for (int i = 0; i < FB_NUM; i++)
            if (widx == 32'(16 + i)) fb_d[i] = merge32(fb_q[i], pwdata, bmask);
         for (int i = 0; i < CH_NUM; i++) begin
            if (widx == 32'(64 + 2 * i)) size_d[i] = merge32(size_q[i], pwdata, bmask);
            if (widx == 32'(65 + 2 * i)) off_d[i]  = merge32(off_q[i], pwdata, bmask);
         end
      end

      if (sts_q) begin
         ovf_d  = '0;
         pend_d = '0;
      end
      // events override any clear issued in the same cycle
      pend_d = pend_d | {finish_i & ~fin_q, |fifo_ovf_i, frame_done_i};
      ovf_d  = ovf_d | fifo_ovf_i;

      if (clear_fire) begin
         fb_d     = '0;
         status_d = '0;
         chen_d   = '0;
         ovf_d    = '0;
         pend_d   = '0;
         en_d     = 1'b0;
         for (int i = 0; i < CH_NUM; i++) begin
            size_d[i] = DEFAULT_SIZE;
            off_d[i]  = rst_off(i);
         end
      end
   end

   // register state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fb_q      <= '0;
         status_q  <= '0;
         chen_q    <= '0;
         ovf_q     <= '0;
         pend_q    <= '0;
         mask_q    <= '0;
         en_q      <= 1'b0;
         en_dly_q  <= 1'b0;
         clr_q     <= 1'b0;
         sts_q     <= 1'b0;
         fin_q     <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         irq_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            size_q[i] <= DEFAULT_SIZE;
            off_q[i]  <= rst_off(i);
         end
      end else begin
         fb_q      <= fb_d;
         size_q    <= size_d;
         off_q     <= off_d;
         status_q  <= status_d;
         chen_q    <= chen_d;
         ovf_q     <= ovf_d;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         en_q      <= en_d;
         en_dly_q  <= en_dly_d;
         clr_q     <= clr_d;
         sts_q     <= sts_d;
         fin_q     <= fin_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         irq_q     <= irq_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign prdata        = prdata_q;
   assign pready        = pready_q;
   assign pslverr       = pslverr_q;
   assign start_o       = start_q;
   assign stop_o        = stop_q;
   assign clear_o       = clear_fire;
   assign fb_addr_o     = fb_q;
   assign status_addr_o = status_q;
   assign ch_enable_o   = chen_q;
   assign ch_size_o     = size_q;
   assign ch_offset_o   = off_q;
   assign irq_o         = irq_q;

endmodule

// File: tb/tb_artec_dma_regs.sv
// Bench for artec_dma_regs: directed scenarios plus randomized APB traffic and
// events, checked every cycle against a register-level model.
module tb_artec_dma_regs;
   localparam int CH = 6;
   localparam int FB = 8;
   localparam int AW = 9;
   localparam logic [31:0] ID  = 32'h0A3D_0001;
   localparam logic [31:0] VER = 32'h0002_0000;
   localparam logic [31:0] DSZ = 32'h0000_1000;
   localparam logic [31:0] STR = 32'h0000_1000;

   logic clk = 1'b0;
   logic rstn, psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [31:0] pwdata, prdata, status_addr_o, frame_status_i, frame_number_i;
   logic [3:0] pstrb;
   logic pready, pslverr, start_o, stop_o, clear_o, irq_o;
   logic [FB*32-1:0] fb_addr_o;
   logic [CH-1:0] ch_enable_o, fifo_ovf_i;
   logic [CH*32-1:0] ch_size_o, ch_offset_o;
   logic finish_i, frame_done_i;

   logic rand_ev = 1'b0;
   logic d_fd = 1'b0, d_fin = 1'b0, r_fd = 1'b0, r_fin = 1'b0;
   logic [CH-1:0] d_ovf = '0, r_ovf = '0;
   assign frame_done_i = rand_ev ? r_fd : d_fd;
   assign finish_i     = rand_ev ? r_fin : d_fin;
   assign fifo_ovf_i   = rand_ev ? r_ovf : d_ovf;

   always #5 clk = ~clk;

   artec_dma_regs #(.APB_ID(ID), .VERSION(VER), .CH_NUM(CH), .FB_NUM(FB), .ADDR_W(AW),
                    .DEFAULT_SIZE(DSZ), .OFFSET_STRIDE(STR)) dut (
      .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .start_o(start_o), .stop_o(stop_o), .clear_o(clear_o),
      .fb_addr_o(fb_addr_o), .status_addr_o(status_addr_o), .ch_enable_o(ch_enable_o),
      .ch_size_o(ch_size_o), .ch_offset_o(ch_offset_o), .irq_o(irq_o),
      .finish_i(finish_i), .frame_done_i(frame_done_i), .frame_status_i(frame_status_i),
      .frame_number_i(frame_number_i), .fifo_ovf_i(fifo_ovf_i));

   int tests = 0, fails = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- register-level model ----------------
   logic [31:0] m_fb [FB];
   logic [31:0] m_size [CH];
   logic [31:0] m_off [CH];
   logic [31:0] m_status, m_prdata;
   logic [CH-1:0] m_chen, m_ovf;
   logic [2:0] m_pend, m_mask;
   logic m_en, m_en_prev, m_clr, m_sts, m_fin, m_irq, m_start, m_stop, m_pready, m_pslverr;

   task automatic m_clear_dp();
      for (int i = 0; i < FB; i++) m_fb[i] = '0;
      for (int i = 0; i < CH; i++) begin m_size[i] = DSZ; m_off[i] = STR * 32'(i); end
      m_status = '0; m_chen = '0; m_ovf = '0; m_pend = '0; m_en = 0; m_en_prev = 0;
   endtask

   task automatic m_reset();
      m_clear_dp();
      m_mask = '0; m_clr = 0; m_sts = 0; m_fin = 0; m_irq = 0; m_start = 0; m_stop = 0;
      m_pready = 0; m_pslverr = 0; m_prdata = '0;
   endtask

   task automatic lookup(input int w, output bit hit, output bit ro, output logic [31:0] v);
      hit = 1; ro = 0; v = '0;
      if (w == 0) begin ro = 1; v = ID; end
      else if (w == 1) begin ro = 1; v = VER; end
      else if (w == 2) begin ro = 1; v = (FB << 16) + CH; end
      else if (w == 3) v = m_en + 2 * m_clr + 4 * m_sts + 8 * m_fin;
      else if (w == 4) begin ro = 1; v = frame_status_i; end
      else if (w == 5) begin ro = 1; v = frame_number_i; end
      else if (w == 6) v = 32'(m_pend);
      else if (w == 7) v = 32'(m_mask);
      else if (w == 8) v = 32'(m_ovf);
      else if (w == 9) v = m_status;
      else if (w == 10) v = 32'(m_chen);
      else if (w >= 16 && w < 16 + FB) v = m_fb[w - 16];
      else if (w >= 64 && w < 64 + 2 * CH) v = (w % 2 == 0) ? m_size[(w - 64) / 2] : m_off[(w - 64) / 2];
      else hit = 0;
   endtask

   function automatic logic [31:0] bytes_in(input logic [31:0] old);
      logic [31:0] v = old;
      for (int b = 0; b < 4; b++) if (pstrb[b]) v[8*b +: 8] = pwdata[8*b +: 8];
      return v;
   endfunction

   task automatic m_write(input int w);
      logic [31:0] t;
      if (w == 3) begin
         if (pstrb[0]) begin m_en = pwdata[0]; m_clr = pwdata[1]; m_sts = pwdata[2]; end
      end else if (w == 6) begin
         for (int b = 0; b < 3; b++) if (pstrb[0] && pwdata[b]) m_pend[b] = 1'b0;
      end else if (w == 7) begin
         t = bytes_in(32'(m_mask)); m_mask = t[2:0];
      end else if (w == 8) begin
         for (int b = 0; b < CH; b++) if (pstrb[b / 8] && pwdata[b]) m_ovf[b] = 1'b0;
      end else if (w == 9) m_status = bytes_in(m_status);
      else if (w == 10) begin
         t = bytes_in(32'(m_chen)); m_chen = t[CH-1:0];
      end else if (w >= 16 && w < 16 + FB) m_fb[w - 16] = bytes_in(m_fb[w - 16]);
      else if (w >= 64 && w < 64 + 2 * CH) begin
         if (w % 2 == 0) m_size[(w - 64) / 2] = bytes_in(m_size[(w - 64) / 2]);
         else m_off[(w - 64) / 2] = bytes_in(m_off[(w - 64) / 2]);
      end
   endtask

   // model advances on each rising edge from the inputs present before it
   int t_w;
   bit t_hit, t_ro, t_first, t_commit, t_fire, t_sts, t_rise, n_irq, n_start, n_stop;
   logic [31:0] t_val;
   always @(posedge clk) begin
      if (!rstn) m_reset();
      else begin
         t_w = int'(paddr[AW-1:2]);
         lookup(t_w, t_hit, t_ro, t_val);
         t_fire   = m_clr && m_fin;
         t_first  = psel && penable && !m_pready;
         t_commit = m_pready && psel && penable && pwrite && t_hit && !t_ro;
         n_irq    = (m_pend & m_mask) != 0;
         n_start  = m_en && !m_en_prev && !t_fire;
         n_stop   = !m_en && m_en_prev && !t_fire;
         m_prdata  = (t_first && !pwrite && t_hit) ? t_val : 32'd0;
         m_pslverr = t_first && (pwrite ? (!t_hit || t_ro) : !t_hit);
         m_pready  = t_first;
         t_sts     = m_sts;
         m_sts     = 0;
         m_en_prev = m_en;
         if (t_fire) m_clr = 0;
         t_rise = finish_i && !m_fin;
         if (t_commit) m_write(t_w);
         if (t_sts) begin m_ovf = '0; m_pend = '0; end
         if (frame_done_i) m_pend[0] = 1'b1;
         if (fifo_ovf_i != 0) m_pend[1] = 1'b1;
         if (t_rise) m_pend[2] = 1'b1;
         m_ovf = m_ovf | fifo_ovf_i;
         m_fin = finish_i;
         if (t_fire) m_clear_dp();
         m_irq = n_irq; m_start = n_start; m_stop = n_stop;
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("pready", pready, m_pready);
         chk("pslverr", pslverr, m_pslverr);
         chk("prdata", prdata, m_prdata);
         chk("start_o", start_o, m_start);
         chk("stop_o", stop_o, m_stop);
         chk("clear_o", clear_o, m_clr & m_fin);
         chk("irq_o", irq_o, m_irq);
         chk("status_addr_o", status_addr_o, m_status);
         chk("ch_enable_o", ch_enable_o, m_chen);
         for (int i = 0; i < FB; i++) chk("fb_addr_o", fb_addr_o[32*i +: 32], m_fb[i]);
         for (int i = 0; i < CH; i++) begin
            chk("ch_size_o", ch_size_o[32*i +: 32], m_size[i]);
            chk("ch_offset_o", ch_offset_o[32*i +: 32], m_off[i]);
         end
      end
   end

   // random event sources
   initial begin
      forever begin
         @(negedge clk);
         r_fd  = ($urandom_range(0, 7) == 0);
         r_ovf = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
         if ($urandom_range(0, 15) == 0) r_fin = ~r_fin;
      end
   end

   task automatic apb(input bit wr, input int w, input logic [31:0] wd, input logic [3:0] st,
                      input bit ovf_pulse, output logic [31:0] rd, output logic err, output int waits);
      @(negedge clk);
      psel = 1; penable = 0; pwrite = wr; paddr = AW'(w * 4); pwdata = wd; pstrb = st;
      @(negedge clk);
      penable = 1;
      waits = 1;
      @(negedge clk);
      while (!pready && waits < 6) begin waits++; @(negedge clk); end
      if (!pready) begin
         tests++; fails++;
         $display("FAIL apb_timeout actual=pready_low required=pready_high word=%0d", w);
      end
      rd = prdata; err = pslverr;
      if (ovf_pulse) d_ovf = CH'(4);
      @(negedge clk);
      psel = 0; penable = 0; d_ovf = '0;
   endtask

   logic [31:0] rd;
   logic err;
   int waits, cnt;

   initial begin
      rstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
      frame_status_i = 32'h0000_00A5; frame_number_i = 32'h0000_0123;
      repeat (3) @(negedge clk);
      cmp_on = 1; rstn = 1;
      chk("rst_pready", pready, 0);
      chk("rst_size0", ch_size_o[31:0], 32'h1000);
      chk("rst_off5", ch_offset_o[5*32 +: 32], 32'h5000);

      apb(0, 0, 0, 4'hF, 0, rd, err, waits);
      chk("rd_id", rd, 32'h0A3D_0001); chk("rd_id_err", err, 0); chk("rd_id_waits", waits, 1);
      apb(0, 1, 0, 4'hF, 0, rd, err, waits);
      chk("rd_ver", rd, 32'h0002_0000); chk("rd_ver_err", err, 0); chk("rd_ver_waits", waits, 1);
      apb(0, 2, 0, 4'hF, 0, rd, err, waits);
      chk("rd_cfg", rd, 32'h0008_0006); chk("rd_cfg_err", err, 0);

      apb(1, 71, 32'h1234_5678, 4'b0011, 0, rd, err, waits);
      @(negedge clk);
      chk("off3_strb", ch_offset_o[3*32 +: 32], 32'h0000_5678);
      apb(0, 71, 0, 4'hF, 0, rd, err, waits);
      chk("off3_rb", rd, 32'h0000_5678);

      apb(1, 3, 1, 4'hF, 0, rd, err, waits);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); cnt += int'(start_o); end
      chk("start_pulses", cnt, 1);
      apb(1, 3, 0, 4'hF, 0, rd, err, waits);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); cnt += int'(stop_o); end
      chk("stop_pulses", cnt, 1);

      apb(1, 16, 32'hDEAD_BEEF, 4'hF, 0, rd, err, waits);
      @(negedge clk);
      chk("fb0_wr", fb_addr_o[31:0], 32'hDEAD_BEEF);
      apb(1, 3, 2, 4'hF, 0, rd, err, waits);
      d_fin = 1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); cnt += int'(clear_o); end
      chk("clear_pulses", cnt, 1);
      chk("fb0_cleared", fb_addr_o[31:0], 0);
      apb(0, 3, 0, 4'hF, 0, rd, err, waits);
      chk("ctrl_after_clear", rd, 32'h8);
      d_fin = 0;

      apb(1, 7, 2, 4'hF, 0, rd, err, waits);
      @(negedge clk); d_ovf = CH'(4);
      @(negedge clk); d_ovf = '0;
      repeat (3) @(negedge clk);
      chk("irq_ovf", irq_o, 1);
      apb(0, 8, 0, 4'hF, 0, rd, err, waits);
      chk("ovf_rd", rd, 32'h4);
      apb(0, 6, 0, 4'hF, 0, rd, err, waits);
      chk("pend_rd", rd, 32'h2);
      apb(1, 6, 2, 4'hF, 1, rd, err, waits);
      apb(0, 6, 0, 4'hF, 0, rd, err, waits);
      chk("pend_set_wins", rd, 32'h2);
      apb(1, 6, 2, 4'hF, 0, rd, err, waits);
      apb(0, 6, 0, 4'hF, 0, rd, err, waits);
      chk("pend_w1c", rd, 32'h0);
      repeat (3) @(negedge clk);
      chk("irq_clr", irq_o, 0);

      apb(1, 4, 32'hFFFF_FFFF, 4'hF, 0, rd, err, waits);
      chk("wr_ro_err", err, 1); chk("wr_ro_data", rd, 0);
      apb(0, 12, 0, 4'hF, 0, rd, err, waits);
      chk("rd_unm_err", err, 1); chk("rd_unm_data", rd, 0);

      apb(1, 9, 32'hCAFE_F00D, 4'hF, 0, rd, err, waits);
      @(negedge clk);
      psel = 1; penable = 0; pwrite = 1; paddr = AW'(9 * 4); pwdata = 32'h1111_2222; pstrb = 4'hF;
      @(negedge clk);
      penable = 1; rstn = 0;
      @(negedge clk);
      chk("rstmid_pready", pready, 0);
      chk("rstmid_pslverr", pslverr, 0);
      chk("rstmid_status", status_addr_o, 0);
      psel = 0; penable = 0; rstn = 1;
      @(negedge clk);

      rand_ev = 1;
      for (int n = 0; n < 400; n++) begin
         int sel, w;
         sel = $urandom_range(0, 4);
         case (sel)
            0: w = $urandom_range(0, 15);
            1: w = 16 + $urandom_range(0, FB + 1);
            2: w = 64 + $urandom_range(0, 2 * CH + 1);
            3: w = $urandom_range(0, 127);
            default: w = (($urandom_range(0, 1) == 1) ? 3 : 6) + $urandom_range(0, 2);
         endcase
         if ($urandom_range(0, 15) == 0) frame_status_i = $urandom;
         if ($urandom_range(0, 15) == 0) frame_number_i = $urandom;
         apb($urandom_range(0, 1) == 1, w, $urandom, 4'($urandom_range(0, 15)), 0, rd, err, waits);
      end
      rand_ev = 0;
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
